// File: rtl/snitch_const_cache_flush_ctrl_if.sv
// Handshake bundle between the flush controller, the demux cache port,
// the cache lookup AR input and the lookup flush port.
interface snitch_const_cache_flush_ctrl_if;
  logic flush_valid;
  logic flush_ready;
  logic slv_ar_valid;
  logic slv_ar_ready;
  logic mst_ar_valid;
  logic mst_ar_ready;
  logic r_valid;
  logic r_ready;
  logic r_last;
  logic cache_flush_valid;
  logic cache_flush_ready;

  // Controller side.
  modport slave (
    input  flush_valid, slv_ar_valid, mst_ar_ready,
    input  r_valid, r_ready, r_last, cache_flush_ready,
    output flush_ready, slv_ar_ready, mst_ar_valid, cache_flush_valid
  );

  // Requester / cache side, as seen from the environment.
  modport master (
    output flush_valid, slv_ar_valid, mst_ar_ready,
    output r_valid, r_ready, r_last, cache_flush_ready,
    input  flush_ready, slv_ar_ready, mst_ar_valid, cache_flush_valid
  );
endinterface

// File: rtl/snitch_const_cache_flush_ctrl.sv
// Constant cache flush sequencer: gates new AR requests, drains outstanding
// cache reads, runs the lookup flush handshake and acknowledges the requester.
module snitch_const_cache_flush_ctrl #(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  snitch_const_cache_flush_ctrl_if.slave bus,
  output logic [CntWidth-1:0]           outstanding_o,
  output logic                          busy_o,
  output logic                          err_o
);

  typedef enum logic [1:0] {
    Idle,
    Drain,
    Flush,
    Ack
  } state_e;

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                gate, inc, dec;
  logic                cache_flush_valid, flush_ready;

  // Closed while any flush is in progress or when the in-flight budget is used up.
  assign gate = (state_q != Idle) | (cnt_q == CntMax);

  assign bus.mst_ar_valid = bus.slv_ar_valid & ~gate;
  assign bus.slv_ar_ready = bus.mst_ar_ready & ~gate;

  assign inc = bus.mst_ar_valid & bus.mst_ar_ready;
  assign dec = bus.r_valid & bus.r_ready & bus.r_last;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CntOne;
    end else if (dec && !inc) begin
      // A last beat with nothing in flight is a protocol error; hold at zero.
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CntOne;
    end
  end

  always_comb begin
    state_d           = state_q;
    cache_flush_valid = 1'b0;
    flush_ready       = 1'b0;
    unique case (state_q)
      Idle:  if (bus.flush_valid) state_d = Drain;
      Drain: if (cnt_q == '0) state_d = Flush;
      Flush: begin
        cache_flush_valid = 1'b1;
        if (bus.cache_flush_ready) state_d = Ack;
      end
      Ack: begin
        flush_ready = 1'b1;
        state_d     = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.cache_flush_valid = cache_flush_valid;
  assign bus.flush_ready       = flush_ready;
  assign outstanding_o         = cnt_q;
  assign busy_o                = (state_q != Idle);
  assign err_o                 = err_q;

endmodule

// File: tb/tb_snitch_const_cache_flush_ctrl.sv
// Self-checking bench for snitch_const_cache_flush_ctrl: scoreboarded counter
// and error expectations plus flush latency expectations.
module tb_snitch_const_cache_flush_ctrl;
  localparam int MaxOut = 8;
  localparam int CntW   = $clog2(MaxOut + 1);

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic [CntW-1:0] outstanding;
  logic            busy, err;

  snitch_const_cache_flush_ctrl_if bus ();

  snitch_const_cache_flush_ctrl #(.MaxOutstanding(MaxOut)) u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .bus           (bus),
    .outstanding_o (outstanding),
    .busy_o        (busy),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_cnt  = 0;
  bit exp_err  = 1'b0;
  int cnt_q[$];
  bit err_q[$];
  int lat_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // One cycle of AR/R stimulus; fl_busy is the expected "not Idle" status this cycle.
  task automatic step(input bit ar, input bit rl, input bit fl_busy);
    bit gate, inc;
    bus.slv_ar_valid = ar;
    bus.mst_ar_ready = 1'b1;
    bus.r_valid      = rl;
    bus.r_ready      = rl;
    bus.r_last       = rl;
    #1;
    gate = fl_busy || (exp_cnt == MaxOut);
    inc  = ar && !gate;
    check("busy", busy, fl_busy);
    check("mst_ar_valid", bus.mst_ar_valid, inc);
    check("slv_ar_ready", bus.slv_ar_ready, !gate);
    if (inc && !rl) exp_cnt++;
    else if (rl && !inc) begin
      if (exp_cnt == 0) exp_err = 1'b1;
      else              exp_cnt--;
    end
    cnt_q.push_back(exp_cnt);
    err_q.push_back(exp_err);
    tick();
    check("outstanding", outstanding, cnt_q.pop_front());
    check("err", err, err_q.pop_front());
  endtask

  // Full flush with cache ready tied high; r_mask selects cycles (relative to
  // the request cycle) that return an R last beat. AR is offered throughout.
  task automatic run_flush(input int exp_cfv, input int exp_ack,
                           input logic [63:0] r_mask, input bit ar_first);
    int  t0, rel, cfv_cnt;
    bit  done;
    lat_q.push_back(exp_cfv);
    lat_q.push_back(exp_ack);
    t0                    = cyc;
    cfv_cnt               = 0;
    done                  = 1'b0;
    bus.flush_valid       = 1'b1;
    bus.cache_flush_ready = 1'b1;
    step(ar_first, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !done; i++) begin
      rel = cyc - t0;
      if (bus.cache_flush_valid) begin
        cfv_cnt++;
        if (cfv_cnt == 1) check("cfv_cycle", rel, lat_q.pop_front());
      end
      if (bus.flush_ready) begin
        if (cfv_cnt == 0) void'(lat_q.pop_front());
        check("ack_cycle", rel, lat_q.pop_front());
        bus.flush_valid = 1'b0;
        done            = 1'b1;
      end
      step(1'b1, r_mask[rel], 1'b1);
    end
    if (!done) check("ack_timeout", 0, 1);
    check("cfv_pulses", cfv_cnt, 1);
    check("ack_single", bus.flush_ready, 0);
    lat_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.flush_valid       = 1'b0;
    bus.slv_ar_valid      = 1'b0;
    bus.mst_ar_ready      = 1'b0;
    bus.r_valid           = 1'b0;
    bus.r_ready           = 1'b0;
    bus.r_last            = 1'b0;
    bus.cache_flush_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_flush_ready", bus.flush_ready, 0);
    check("rst_cfv", bus.cache_flush_valid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst_ni = 1'b1;

    // Minimum latency flush from an empty pipe.
    run_flush(2, 3, 64'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Three reads in flight, last beats returned at +5, +7, +9.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    run_flush(11, 12, (64'd1 << 5) | (64'd1 << 7) | (64'd1 << 9), 1'b0);

    // Fill to the limit, then one last beat frees a slot for the blocked AR.
    for (int i = 0; i < MaxOut; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Drain to 4, then simultaneous AR handshake and R last.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    // Flush request in the same cycle as an accepted AR: 5 reads drained first.
    run_flush(7, 8, 64'h3E, 1'b1);

    // Underflow sets a sticky error.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset while stuck in Flush.
    bus.flush_valid       = 1'b1;
    bus.cache_flush_ready = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("stall_cfv", bus.cache_flush_valid, 1);
    step(1'b0, 1'b0, 1'b1);
    check("stall_cfv_held", bus.cache_flush_valid, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_cfv", bus.cache_flush_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_outstanding", outstanding, 0);
    check("arst_err", err, 0);
    check("arst_flush_ready", bus.flush_ready, 0);
    exp_cnt               = 0;
    exp_err               = 1'b0;
    bus.flush_valid       = 1'b0;
    bus.cache_flush_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
